axi4_lite_reg_bank: RTL

AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

---
 rtl/axi4_lite_reg_bank_pkg.sv | 25 ++
 rtl/axi4_lite_wr_skid.sv | 101 ++++++++++
 rtl/axi4_lite_reg_bank.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// Covers response codes, CTRL bit positions and the byte-lane merge helper.
package axi4_lite_reg_bank_pkg;

    localparam int ADDR_LSB        = 2;
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_wr_skid.sv
// Write-channel capture: one-entry AW and W holding registers plus B response.
// A write executes once both are held and no response is pending.
module axi4_lite_wr_skid
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    output logic                    wr_exec,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_err
);

    logic                    aw_full_r, w_full_r, bvalid_r, awready_r, wready_r;
    logic [ADDR_WIDTH-1:0]   aw_addr_r;
    logic [DATA_WIDTH-1:0]   w_data_r;
    logic [DATA_WIDTH/8-1:0] w_strb_r;
    logic [1:0]              bresp_r;
    logic                    exec_s, aw_full_next_s, w_full_next_s, bvalid_next_s;

    assign exec_s = aw_full_r & w_full_r & ~bvalid_r;

    // Next occupancy of the holding registers and the response flag.
    always_comb begin
        aw_full_next_s = aw_full_r;
        w_full_next_s  = w_full_r;
        bvalid_next_s  = bvalid_r;
        if (exec_s) begin
            aw_full_next_s = 1'b0;
            w_full_next_s  = 1'b0;
            bvalid_next_s  = 1'b1;
        end else begin
            if (awvalid & awready_r) begin
                aw_full_next_s = 1'b1;
            end else begin
                aw_full_next_s = aw_full_r;
            end
            if (wvalid & wready_r) begin
                w_full_next_s = 1'b1;
            end else begin
                w_full_next_s = w_full_r;
            end
            if (bvalid_r & bready) begin
                bvalid_next_s = 1'b0;
            end else begin
                bvalid_next_s = bvalid_r;
            end
        end
    end

    // Holding registers; readies reopen only once the response has been taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
            bresp_r   <= 2'b00;
        end else begin
            aw_full_r <= aw_full_next_s;
            w_full_r  <= w_full_next_s;
            bvalid_r  <= bvalid_next_s;
            awready_r <= ~aw_full_next_s & ~bvalid_next_s;
            wready_r  <= ~w_full_next_s & ~bvalid_next_s;
            if (awvalid & awready_r) aw_addr_r <= awaddr;
            if (wvalid & wready_r) begin
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
            if (exec_s) bresp_r <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign wr_exec = exec_s;
    assign wr_addr = aw_addr_r;
    assign wr_data = w_data_r;
    assign wr_strb = w_strb_r;

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite register bank: writes land in shadow registers and are copied to
// o_reg_data on an explicit or automatic commit; read-only slots show i_reg_data.
module axi4_lite_reg_bank
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int                          C_S_AXI_DATA_WIDTH = 32,
    parameter int                          C_S_AXI_ADDR_NUM   = 128,
    parameter int                          C_S_AXI_ADDR_WIDTH = $clog2(C_S_AXI_ADDR_NUM) + 2,
    parameter logic [C_S_AXI_ADDR_NUM-1:0] C_RW_MASK          = '1
) (
    input  logic                                         S_AXI_ACLK,
    input  logic                                         S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_NUM*C_S_AXI_DATA_WIDTH-1:0] o_reg_data,
    input  logic [C_S_AXI_ADDR_NUM*C_S_AXI_DATA_WIDTH-1:0] i_reg_data,
    output logic                                         o_commit,
    output logic [C_S_AXI_ADDR_NUM-1:0]                  o_wr_strobe
);

    localparam int             NUM     = C_S_AXI_ADDR_NUM;
    localparam int             DW      = C_S_AXI_DATA_WIDTH;
    localparam int             IDX_W   = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [NUM-1:0] RW_MASK = C_RW_MASK | {{(NUM-1){1'b0}}, 1'b1};

    logic                          wr_exec_s, wr_rw_s, wr_apply_s, commit_req_s, ar_accept_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_s;
    logic [DW-1:0]                 wr_data_s, merged_s;
    logic [DW/8-1:0]               wr_strb_s;
    logic [IDX_W-1:0]              wr_idx_s, ar_idx_s;
    logic [DW-1:0]                 shadow_r [NUM];
    logic [DW-1:0]                 shadow_next_s [NUM];
    logic [NUM*DW-1:0]             reg_data_r;
    logic [NUM-1:0]                strobe_s, strobe_r;
    logic                          commit_r, arready_r, rvalid_r;
    logic [DW-1:0]                 rdata_r;
    logic [1:0]                    rresp_r;
    logic                          unused_s;

    axi4_lite_wr_skid #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .DATA_WIDTH (DW)
    ) u_wr_skid (
        .clk     (S_AXI_ACLK),
        .reset   (S_AXI_ARESET),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .awaddr  (S_AXI_AWADDR),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .bresp   (S_AXI_BRESP),
        .wr_exec (wr_exec_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .wr_strb (wr_strb_s),
        .wr_err  (~wr_rw_s)
    );

    assign wr_idx_s   = wr_addr_s[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_rw_s    = RW_MASK[wr_idx_s];
    assign wr_apply_s = wr_exec_s & wr_rw_s;
    assign merged_s   = byte_merge(shadow_r[wr_idx_s], wr_data_s, wr_strb_s);

    // Next shadow contents; CTRL keeps only AUTO, COMMIT acts as a trigger.
    always_comb begin
        for (int i = 0; i < NUM; i++) shadow_next_s[i] = shadow_r[i];
        strobe_s     = '0;
        commit_req_s = 1'b0;
        if (wr_apply_s) begin
            strobe_s[wr_idx_s] = 1'b1;
            if (wr_idx_s == {IDX_W{1'b0}}) begin
                shadow_next_s[0]                = '0;
                shadow_next_s[0][CTRL_AUTO_BIT] = merged_s[CTRL_AUTO_BIT];
                commit_req_s = merged_s[CTRL_COMMIT_BIT] | shadow_r[0][CTRL_AUTO_BIT];
            end else begin
                shadow_next_s[wr_idx_s] = merged_s;
                commit_req_s            = shadow_r[0][CTRL_AUTO_BIT];
            end
        end else begin
            commit_req_s = 1'b0;
        end
    end

    // Shadow storage and commit copy into the live outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM; i++) shadow_r[i] <= '0;
            reg_data_r <= '0;
            commit_r   <= 1'b0;
            strobe_r   <= '0;
        end else begin
            for (int i = 0; i < NUM; i++) shadow_r[i] <= shadow_next_s[i];
            if (commit_req_s) begin
                for (int i = 0; i < NUM; i++) reg_data_r[i*DW +: DW] <= shadow_next_s[i];
            end
            commit_r <= commit_req_s;
            strobe_r <= strobe_s;
        end
    end

    assign ar_idx_s    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_accept_s = S_AXI_ARVALID & arready_r;

    // Read path; data is captured from the pre-write shadow in the accept cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
        end else begin
            arready_r <= S_AXI_ARVALID & ~arready_r & ~rvalid_r;
            if (ar_accept_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= RESP_OKAY;
                rdata_r  <= RW_MASK[ar_idx_s] ? shadow_r[ar_idx_s]
                                              : i_reg_data[ar_idx_s*DW +: DW];
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign o_reg_data    = reg_data_r;
    assign o_commit      = commit_r;
    assign o_wr_strobe   = strobe_r;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0],
                        wr_addr_s[ADDR_LSB-1:0]};

endmodule
